// File: rtl/ft6206_pkg.sv
// FT6206 touch controller shared definitions.
package ft6206_pkg;

    localparam int unsigned FT6206_COORD_W = 12;

    // One decoded touch sample as delivered by the FT6206 front end.
    typedef struct packed {
        logic                      valid;
        logic [1:0]                evt;
        logic [FT6206_COORD_W-1:0] x;
        logic [FT6206_COORD_W-1:0] y;
    } touch_t;

endpackage

// File: rtl/ili9341_pkg.sv
// ILI9341 display shared definitions: RGB565 colour type and drawing palette.
package ili9341_pkg;

    typedef logic [15:0] ILI9341_color_t;

    localparam ILI9341_color_t WHITE = 16'hFFFF;
    localparam ILI9341_color_t BLACK = 16'h0000;

    localparam int unsigned ILI9341_PALETTE_N = 8;

    localparam ILI9341_color_t ILI9341_PALETTE [ILI9341_PALETTE_N] = '{
        WHITE,      // white
        16'hF800,   // red
        16'h07E0,   // green
        16'h001F,   // blue
        16'hFFE0,   // yellow
        16'h07FF,   // cyan
        16'hF81F,   // magenta
        BLACK       // black
    };

endpackage

// File: rtl/touch_vram_painter_pkg.sv
// Painter-local definitions: FSM encoding and coordinate range helper.
package touch_vram_painter_pkg;
    import ft6206_pkg::*;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PAINT = 2'd1;
    localparam logic [1:0] S_CLEAR = 2'd2;

    // True when a signed coordinate (one bit wider than the touch field) lies in [0, lim-1].
    function automatic logic in_span(input logic [FT6206_COORD_W:0] c, input int unsigned lim);
        return !c[FT6206_COORD_W] && (32'(c[FT6206_COORD_W-1:0]) < lim);
    endfunction

endpackage

// File: rtl/xy_to_vram_addr.sv
// Combinational pixel coordinate to linear VRAM address mapping.
module xy_to_vram_addr #(
    parameter int unsigned DISPLAY_WIDTH = 240,
    parameter int unsigned X_W           = 12,
    parameter int unsigned Y_W           = 12,
    parameter int unsigned ADDR_W        = 17
) (
    input  logic [X_W-1:0]    x_i,
    input  logic [Y_W-1:0]    y_i,
    output logic [ADDR_W-1:0] addr_o
);

    // Row-major layout: y * width + x.
    assign addr_o = ADDR_W'(32'(y_i) * DISPLAY_WIDTH + 32'(x_i));

endmodule

// File: rtl/touch_vram_painter.sv
// Brush-stamping VRAM writer driven by touch samples, with full-frame clear.
module touch_vram_painter
    import ili9341_pkg::*;
    import ft6206_pkg::*;
    import touch_vram_painter_pkg::*;
#(
    parameter int unsigned DISPLAY_WIDTH  = 240,
    parameter int unsigned DISPLAY_HEIGHT = 320,
    parameter int unsigned VRAM_L         = DISPLAY_WIDTH * DISPLAY_HEIGHT,
    parameter int unsigned BRUSH_SIZE     = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ena,
    input  touch_t                    touch,
    input  logic                      clear_req,
    input  logic                      color_next,
    output logic                      vram_wr_ena,
    output logic [$clog2(VRAM_L)-1:0] vram_wr_addr,
    output ILI9341_color_t            vram_wr_data,
    output logic                      busy,
    output logic [2:0]                color_idx
);

    localparam int unsigned AW = $clog2(VRAM_L);
    localparam int unsigned BL = $clog2(BRUSH_SIZE);
    localparam int unsigned PW = 2 * BL;
    localparam int unsigned CW = FT6206_COORD_W;
    localparam int unsigned SW = CW + 1;
    localparam logic [PW-1:0] PIX_LAST = PW'(BRUSH_SIZE * BRUSH_SIZE - 1);

    logic [1:0]     state_q, state_d;
    logic [PW-1:0]  pix_q, pix_d, pix_nx;
    logic [SW-1:0]  x0_q, x0_d, y0_q, y0_d;
    logic [SW-1:0]  org_x, org_y, base_x, base_y, tgt_x, tgt_y;
    ILI9341_color_t color_q, color_d;
    logic           last_v_q, last_v_d;
    logic [CW-1:0]  last_x_q, last_x_d, last_y_q, last_y_d;
    logic           pend_q, pend_d;
    logic [2:0]     idx_q, idx_d;
    logic           wr_ena_q, wr_ena_d;
    logic [AW-1:0]  wr_addr_q, wr_addr_d, tgt_addr;
    ILI9341_color_t wr_data_q, wr_data_d;
    logic           busy_q, busy_d;
    logic           tgt_in, touch_in, touch_new;
    logic           unused_touch_bits;

    assign unused_touch_bits = ^touch.evt;

    // Pixel targeted by the next write slot: brush origin of a fresh touch, or the next raster offset.
    assign org_x  = {1'b0, touch.x} - SW'(BRUSH_SIZE / 2);
    assign org_y  = {1'b0, touch.y} - SW'(BRUSH_SIZE / 2);
    assign pix_nx = (state_q == S_IDLE) ? '0 : pix_q + PW'(1);
    assign base_x = (state_q == S_IDLE) ? org_x : x0_q;
    assign base_y = (state_q == S_IDLE) ? org_y : y0_q;
    assign tgt_x  = base_x + SW'(pix_nx[BL-1:0]);
    assign tgt_y  = base_y + SW'(pix_nx[PW-1:BL]);
    assign tgt_in = in_span(tgt_x, DISPLAY_WIDTH) && in_span(tgt_y, DISPLAY_HEIGHT);

    assign touch_in  = in_span({1'b0, touch.x}, DISPLAY_WIDTH) &&
                       in_span({1'b0, touch.y}, DISPLAY_HEIGHT);
    assign touch_new = !last_v_q || (touch.x != last_x_q) || (touch.y != last_y_q);

    xy_to_vram_addr #(
        .DISPLAY_WIDTH (DISPLAY_WIDTH),
        .X_W           (CW),
        .Y_W           (CW),
        .ADDR_W        (AW)
    ) u_addr (
        .x_i    (tgt_x[CW-1:0]),
        .y_i    (tgt_y[CW-1:0]),
        .addr_o (tgt_addr)
    );

    // Next-state and next-write-slot logic.
    always_comb begin
        state_d   = state_q;
        pix_d     = pix_q;
        x0_d      = x0_q;
        y0_d      = y0_q;
        color_d   = color_q;
        last_v_d  = last_v_q;
        last_x_d  = last_x_q;
        last_y_d  = last_y_q;
        pend_d    = pend_q;
        idx_d     = color_next ? idx_q + 3'd1 : idx_q;
        wr_ena_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        case (state_q)
            S_IDLE: begin
                if (clear_req || pend_q) begin
                    state_d   = S_CLEAR;
                    pend_d    = 1'b0;
                    wr_ena_d  = 1'b1;
                    wr_addr_d = '0;
                    wr_data_d = BLACK;
                end else if (touch.valid && touch_in && touch_new) begin
                    state_d   = S_PAINT;
                    pix_d     = '0;
                    x0_d      = org_x;
                    y0_d      = org_y;
                    color_d   = ILI9341_PALETTE[idx_q];
                    last_v_d  = 1'b1;
                    last_x_d  = touch.x;
                    last_y_d  = touch.y;
                    wr_ena_d  = tgt_in;
                    wr_addr_d = tgt_addr;
                    wr_data_d = ILI9341_PALETTE[idx_q];
                end
            end
            S_PAINT: begin
                if (clear_req) begin
                    pend_d = 1'b1;
                end
                if (pix_q == PIX_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    pix_d     = pix_nx;
                    wr_ena_d  = tgt_in;
                    wr_addr_d = tgt_addr;
                    wr_data_d = color_q;
                end
            end
            S_CLEAR: begin
                if (wr_addr_q == AW'(VRAM_L - 1)) begin
                    state_d  = S_IDLE;
                    last_v_d = 1'b0;
                end else begin
                    wr_ena_d  = 1'b1;
                    wr_addr_d = wr_addr_q + AW'(1);
                    wr_data_d = BLACK;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and registered write port; everything freezes while ena is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pix_q     <= '0;
            x0_q      <= '0;
            y0_q      <= '0;
            color_q   <= '0;
            last_v_q  <= 1'b0;
            last_x_q  <= '0;
            last_y_q  <= '0;
            pend_q    <= 1'b0;
            idx_q     <= '0;
            wr_ena_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
        end else if (ena) begin
            state_q   <= state_d;
            pix_q     <= pix_d;
            x0_q      <= x0_d;
            y0_q      <= y0_d;
            color_q   <= color_d;
            last_v_q  <= last_v_d;
            last_x_q  <= last_x_d;
            last_y_q  <= last_y_d;
            pend_q    <= pend_d;
            idx_q     <= idx_d;
            wr_ena_q  <= wr_ena_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
        end
    end

    // A pending slot is only committed while ena is high, so a stall never drops or repeats a pixel.
    assign vram_wr_ena  = wr_ena_q & ena;
    assign vram_wr_addr = wr_addr_q;
    assign vram_wr_data = wr_data_q;
    assign busy         = busy_q;
    assign color_idx    = idx_q;

endmodule

// File: tb/tb_touch_vram_painter.sv
// Self-checking bench for touch_vram_painter with a pixel-level reference model.
module tb_touch_vram_painter;
    import ft6206_pkg::*;

    localparam int W  = 240;
    localparam int H  = 320;
    localparam int B  = 4;
    localparam int VL = W * H;

    typedef struct { int addr; int data; int t; } wr_t;
    typedef struct { string name; int x; int y; int n; int first; int last; int busy; } vec_t;

    logic        clk = 1'b0;
    logic        rst, ena, clear_req, color_next;
    touch_t      touch;
    logic        vram_wr_ena;
    logic [16:0] vram_wr_addr;
    logic [15:0] vram_wr_data;
    logic        busy;
    logic [2:0]  color_idx;

    int  n_checks = 0;
    int  n_errors = 0;
    int  cyc = 0;
    int  t0 = 0;
    int  busy_cnt = 0;
    int  stall_viol = 0;
    wr_t obs[$];
    wr_t expq[$];
    int  m_idx = 0;
    int  m_lx = 0;
    int  m_ly = 0;
    bit  m_lv = 1'b0;
    int  pal[8] = '{'hFFFF, 'hF800, 'h07E0, 'h001F, 'hFFE0, 'h07FF, 'hF81F, 'h0000};
    vec_t vecs[6];

    touch_vram_painter dut (
        .clk          (clk),
        .rst          (rst),
        .ena          (ena),
        .touch        (touch),
        .clear_req    (clear_req),
        .color_next   (color_next),
        .vram_wr_ena  (vram_wr_ena),
        .vram_wr_addr (vram_wr_addr),
        .vram_wr_data (vram_wr_data),
        .busy         (busy),
        .color_idx    (color_idx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Write-port monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (vram_wr_ena) obs.push_back('{int'(vram_wr_addr), int'(vram_wr_data), cyc - t0});
        if (vram_wr_ena && !ena) stall_viol++;
        if (busy) busy_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    // Reference: a touch paints every in-frame pixel of the brush square, raster order, one slot per offset.
    task automatic model_touch(input int x, input int y);
        int px, py;
        if (x < W && y < H && (!m_lv || x != m_lx || y != m_ly)) begin
            m_lv = 1'b1;
            m_lx = x;
            m_ly = y;
            for (int dy = 0; dy < B; dy++) begin
                for (int dx = 0; dx < B; dx++) begin
                    px = x - B / 2 + dx;
                    py = y - B / 2 + dy;
                    if (px >= 0 && px < W && py >= 0 && py < H)
                        expq.push_back('{py * W + px, pal[m_idx], dy * B + dx + 1});
                end
            end
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < VL; i++) expq.push_back('{i, 0, 0});
        m_lv = 1'b0;
    endtask

    task automatic pulse_touch(input int x, input int y);
        touch.valid = 1'b1;
        touch.x     = 12'(x);
        touch.y     = 12'(y);
        t0 = cyc;
        tick();
        touch.valid = 1'b0;
    endtask

    task automatic pulse_color();
        color_next = 1'b1;
        m_idx = (m_idx + 1) % 8;
        tick();
        color_next = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        if (busy) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: still busy after %0d cycles", name, budget);
        end
    endtask

    // Compare observed write stream with the model stream, then empty both.
    task automatic cmp_stream(input string name, input bit use_t);
        int nbad, fi;
        nbad = 0;
        fi = -1;
        n_checks++;
        for (int i = 0; i < obs.size() && i < expq.size(); i++) begin
            if (obs[i].addr != expq[i].addr || obs[i].data != expq[i].data ||
                (use_t && obs[i].t != expq[i].t)) begin
                nbad++;
                if (fi < 0) fi = i;
            end
        end
        if (nbad != 0 || obs.size() != expq.size()) begin
            n_errors++;
            if (fi >= 0)
                $display("FAIL %s: got %0d writes, %0d differ; at #%0d got addr=%0d data=%0h t=%0d, required addr=%0d data=%0h t=%0d (required %0d writes)",
                         name, obs.size(), nbad, fi, obs[fi].addr, obs[fi].data, obs[fi].t,
                         expq[fi].addr, expq[fi].data, expq[fi].t, expq.size());
            else
                $display("FAIL %s: got %0d writes, required %0d writes", name, obs.size(), expq.size());
        end
        obs.delete();
        expq.delete();
    endtask

    initial begin
        int rx, ry;
        vecs[0] = '{"interior",   100, 100, 16, 23618, 24341, 16};
        vecs[1] = '{"corner",       0,   0,  4,     0,   241, 16};
        vecs[2] = '{"repeat",       0,   0,  0,     0,     0,  0};
        vecs[3] = '{"far_corner", 239, 319,  9, 76317, 76799, 16};
        vecs[4] = '{"outside",    240,   5,  0,     0,     0,  0};
        vecs[5] = '{"top_edge",     5,   0,  8,     3,   246, 16};

        rst = 1'b1; ena = 1'b1; clear_req = 1'b0; color_next = 1'b0; touch = '0;
        tick(); tick();
        rst = 1'b0;
        repeat (3) tick();
        check("rst_wr_ena", vram_wr_ena, 0);
        check("rst_wr_addr", vram_wr_addr, 0);
        check("rst_wr_data", vram_wr_data, 0);
        check("rst_busy", busy, 0);
        check("rst_color_idx", color_idx, 0);
        check("rst_no_writes", obs.size(), 0);
        obs.delete();

        // Table of single strokes with white brush.
        for (int i = 0; i < 6; i++) begin
            obs.delete(); expq.delete(); busy_cnt = 0;
            model_touch(vecs[i].x, vecs[i].y);
            pulse_touch(vecs[i].x, vecs[i].y);
            repeat (20) tick();
            check({vecs[i].name, "_count"}, obs.size(), vecs[i].n);
            if (vecs[i].n > 0 && obs.size() > 0) begin
                check({vecs[i].name, "_first"}, obs[0].addr, vecs[i].first);
                check({vecs[i].name, "_last"}, obs[obs.size() - 1].addr, vecs[i].last);
            end
            check({vecs[i].name, "_busy"}, busy_cnt, vecs[i].busy);
            cmp_stream({vecs[i].name, "_stream"}, 1'b1);
        end

        // Palette wrap, then a red stroke that ignores a mid-stroke colour change.
        repeat (9) begin pulse_color(); tick(); end
        check("color_wrap", color_idx, 1);
        model_touch(120, 160);
        pulse_touch(120, 160);
        repeat (4) tick();
        pulse_color();
        repeat (20) tick();
        check("red_data", obs.size() > 0 ? obs[0].data : -1, 'hF800);
        check("color_after", color_idx, m_idx);
        cmp_stream("color_stream", 1'b1);

        // Enable stall mid-stroke.
        busy_cnt = 0; stall_viol = 0;
        model_touch(60, 60);
        pulse_touch(60, 60);
        repeat (3) tick();
        ena = 1'b0;
        repeat (5) tick();
        ena = 1'b1;
        repeat (25) tick();
        check("stall_strobe", stall_viol, 0);
        check("stall_busy", busy_cnt, 21);
        cmp_stream("stall_stream", 1'b0);

        // Clear requested during a stroke, second request mid-clear ignored.
        model_touch(50, 50);
        pulse_touch(50, 50);
        tick(); tick();
        pulse_clear();
        model_clear();
        repeat (25) tick();
        check("clear_busy", busy, 1);
        repeat (1000) tick();
        pulse_clear();
        wait_idle("clear_done", 80000);
        repeat (3) tick();
        cmp_stream("clear_stream", 1'b0);

        // Last point is forgotten after a clear.
        model_touch(50, 50);
        pulse_touch(50, 50);
        repeat (20) tick();
        cmp_stream("retouch_stream", 1'b1);

        // Randomized strokes, palette steps and stalls against the model.
        stall_viol = 0;
        for (int k = 0; k < 30; k++) begin
            rx = $urandom_range(0, 259);
            ry = $urandom_range(0, 339);
            if (m_lv && $urandom_range(0, 3) == 0) begin rx = m_lx; ry = m_ly; end
            repeat ($urandom_range(0, 2)) pulse_color();
            model_touch(rx, ry);
            pulse_touch(rx, ry);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(0, 10)) tick();
                ena = 1'b0;
                repeat ($urandom_range(1, 6)) tick();
                ena = 1'b1;
            end
            repeat (25) tick();
        end
        check("rand_strobe", stall_viol, 0);
        check("rand_color_idx", color_idx, m_idx);
        cmp_stream("rand_stream", 1'b0);

        // Reset aborts a clear.
        pulse_clear();
        repeat (100) tick();
        check("preabort_busy", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("abort_wr_ena", vram_wr_ena, 0);
        check("abort_busy", busy, 0);
        check("abort_color_idx", color_idx, 0);
        obs.delete(); expq.delete();
        m_idx = 0; m_lv = 1'b0;
        repeat (20) tick();
        check("abort_no_writes", obs.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/touch_vram_painter.md
# touch_vram_painter

Drawing engine that sits directly upstream of the ILI9341 display controller's video RAM. It consumes touch samples from the FT6206 touch controller and stamps a square brush of the current palette colour into VRAM, one pixel write per cycle. It also sweeps the whole frame to black on a clear request. The display controller reads the same VRAM through its own read port; this block owns the write port only.

## Interface

Parameters:
- `DISPLAY_WIDTH`, default 240: pixels per row.
- `DISPLAY_HEIGHT`, default 320: rows per frame.
- `VRAM_L`, default `DISPLAY_WIDTH*DISPLAY_HEIGHT`: VRAM depth in pixels.
- `BRUSH_SIZE`, default 4: brush edge length in pixels; must be an even power of two, from 2 to 16.

Ports:
- `clk`, in, 1: the single clock.
- `rst`, in, 1: reset, synchronous and active-high.
- `ena`, in, 1: advance enable. When low, all state and outputs hold, and `vram_wr_ena` is forced to 0.
- `touch`, in, `touch_t`: FT6206 sample; only fields `valid`, `x`, `y` are used.
- `clear_req`, in, 1: single-cycle pulse requesting a full-frame clear.
- `color_next`, in, 1: single-cycle pulse advancing the palette index.
- `vram_wr_ena`, out, 1: VRAM write strobe.
- `vram_wr_addr`, out, `$clog2(VRAM_L)`: write address, computed as `y*DISPLAY_WIDTH + x`.
- `vram_wr_data`, out, 16: RGB565 pixel value.
- `busy`, out, 1: high in every state except S_IDLE.
- `color_idx`, out, 3: current palette index.

## Operation

The block has three states: S_IDLE, S_PAINT, S_CLEAR.

**S_IDLE**
- If `clear_req` is high, or `clear_pending` is set, go to S_CLEAR with the counter at 0, and clear `clear_pending`.
- Otherwise, if `touch.valid` is high and (`touch.x`, `touch.y`) differs from the last painted point (or no point has been painted since reset/clear), do the following:
  - Latch the origin: `x0 = touch.x - BRUSH_SIZE/2`, `y0 = touch.y - BRUSH_SIZE/2`. Compute these as signed, one bit wider than the coordinate.
  - Latch the stroke colour as `palette[color_idx]`.
  - Record (`touch.x`, `touch.y`) as the last painted point.
  - Go to S_PAINT with offsets `dx = dy = 0`.
- Touch samples whose coordinates lie outside the display are ignored, and the last painted point is not updated.

**S_PAINT**
- Visit offsets in raster order: `dx` advances fastest, running 0 to `BRUSH_SIZE-1`; then `dy` advances.
- The target pixel is (`x0+dx`, `y0+dy`).
- A target inside `[0, DISPLAY_WIDTH-1] x [0, DISPLAY_HEIGHT-1]` is written: `vram_wr_ena=1` for that cycle.
- A target outside that range is clipped: `vram_wr_ena=0`, but the cycle is still consumed.
- The pass always takes exactly `BRUSH_SIZE²` cycles. After the last offset, return to S_IDLE.

**S_CLEAR**
- Write `BLACK` to addresses 0 through `VRAM_L-1`, one address per cycle.
- After address `VRAM_L-1`, return to S_IDLE and forget the last painted point.

**Palette**
- The palette has 8 entries: WHITE, RED, GREEN, BLUE, YELLOW, CYAN, MAGENTA, BLACK.
- A `color_next` pulse increments `color_idx` in any state, wrapping from 7 to 0.
- A stroke already in progress keeps its latched colour.

**Simultaneous events**
- `clear_req` together with `touch.valid` in S_IDLE: the clear wins, and the touch is dropped.
- `clear_req` during S_PAINT: set `clear_pending`; the clear starts on the cycle after the paint pass finishes.
- `clear_req` during S_CLEAR: ignored.

## Timing

Reset values:
- state = S_IDLE
- `vram_wr_ena` = 0, `vram_wr_addr` = 0, `vram_wr_data` = 0
- `busy` = 0, `color_idx` = 0
- `clear_pending` = 0
- last painted point invalid

Reset asserted during S_PAINT or S_CLEAR aborts the operation immediately. No further writes are issued.

Write outputs are registered:
- A touch accepted in cycle N gives the first write slot in cycle N+1.
- A paint pass occupies cycles N+1 through N+`BRUSH_SIZE²`; S_IDLE is re-entered at N+`BRUSH_SIZE²`+1.
- A clear occupies exactly `VRAM_L` write cycles.
- `busy` is registered and is high for exactly the cycles spent in S_PAINT or S_CLEAR.

With `ena` low, the write port sees no strobe and the counters freeze. The operation resumes when `ena` returns high, with no lost or duplicated addresses.

## Structure

- The 8-entry palette array and the `BLACK`/`WHITE` constants belong in the shared ILI9341 defines package, typed `ILI9341_color_t`.
- `touch_t` comes from the FT6206 defines package; do not redeclare it.
- One sub-module is natural: `xy_to_vram_addr`. It is combinational, computes `y*DISPLAY_WIDTH + x`, and is shared with any future VRAM writer.

## Test plan

- **Reset and idle:** hold `rst` for 2 cycles, then release with no input -> all outputs stay 0 and `color_idx=0`.
- **Interior stroke:** touch (100,100) valid for 1 cycle, `BRUSH_SIZE=4` -> 16 writes of `WHITE`. The first address is 23618 (98,98); the last is 24341 (101,101). `busy` is high for exactly 16 cycles.
- **Corner clip:** touch (0,0) -> exactly 4 writes, to addresses 0, 1, 240, 241. `busy` is still high for 16 cycles. A repeated touch at (0,0) produces no writes.
- **Clear during paint:** touch (50,50), then `clear_req` 3 cycles later -> the paint pass completes, then 76800 `BLACK` writes at addresses 0 through 76799. A second `clear_req` mid-clear is ignored.
- **Colour change:** pulse `color_next` 9 times -> `color_idx=1`. A stroke started afterwards writes `RED`. A `color_next` pulse mid-stroke does not change that stroke's data.
- **Stall and reset:** deassert `ena` for 5 cycles mid-stroke -> no strobes during the stall, and the address sequence resumes unbroken. Assert `rst` mid-clear -> `vram_wr_ena=0` on the next cycle and the block returns to S_IDLE.
